// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the fetch/status unit
//
// Purpose: PC-select encodings, fetch FSM state encodings, NZCV bit positions
//          and the branch-offset helper shared by the fetch unit and its
//          PC next-value logic.
// Ports:   none (package)

package cpu_pkg;

   typedef enum logic [1:0] {
      PC_HOLD   = 2'b00,
      PC_INC4   = 2'b01,
      PC_BRANCH = 2'b10,
      PC_LOAD   = 2'b11
   } pc_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_VALID = 2'b10
   } fetch_state_e;

   // NZCV bit positions within alu_flags / status
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Word offset k, sign-extended to 64 bits and scaled to a byte offset.
   function automatic logic [63:0] branch_offset(input logic [31:0] k);
      return {{30{k[31]}}, k, 2'b00};
   endfunction

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - program counter next-value selection
//
// Purpose: computes the candidate next PC from the current PC and pc_sel.
//          Purely combinational; the caller decides when to load it.
// Ports:
//   pc_i      in  64  current program counter
//   pc_sel_i  in   2  hold / +4 / PC-relative branch / absolute load
//   k_i       in  32  signed word offset for branches
//   pc_in_i   in  64  absolute target
//   next_pc_o out 64  selected next PC (arithmetic wraps modulo 2^64)

module pc_next
   import cpu_pkg::*;
(
   input  logic    [63:0] pc_i,
   input  pc_sel_e        pc_sel_i,
   input  logic    [31:0] k_i,
   input  logic    [63:0] pc_in_i,
   output logic    [63:0] next_pc_o
);

   always_comb begin
      next_pc_o = pc_i;
      case (pc_sel_i)
         PC_HOLD:   next_pc_o = pc_i;
         PC_INC4:   next_pc_o = pc_i + 64'd4;
         PC_BRANCH: next_pc_o = pc_i + branch_offset(k_i);
         PC_LOAD:   next_pc_o = pc_in_i;
      endcase
   end

endmodule

// File: rtl/fetch_status_unit.sv
// rtl/fetch_status_unit.sv - instruction fetch FSM, PC and NZCV status register
//
// Purpose: holds the PC, issues instruction reads, latches the returned word
//          into the IR, flags a fetch timeout, and keeps the NZCV status.
// Ports:
//   clock        in   1  rising-edge clock
//   reset        in   1  synchronous active-high reset
//   fetch_start  in   1  request the next instruction
//   pc_sel       in   2  PC update select (applied in IDLE/VALID only)
//   k            in  32  signed word offset for PC-relative branch
//   pc_in        in  64  absolute PC target
//   alu_flags    in   4  NZCV from the datapath
//   flags_we     in   1  status write enable
//   mem_req      out  1  instruction read request (high throughout FETCH)
//   mem_addr     out 64  read address, always equal to pc
//   mem_rdata    in  32  instruction word, valid with mem_ack
//   mem_ack      in   1  read completes this cycle
//   ir           out 32  instruction register
//   ir_valid     out  1  ir holds a freshly fetched instruction
//   pc           out 64  program counter
//   status       out  4  registered NZCV
//   fetch_err    out  1  one-cycle pulse on fetch timeout

module fetch_status_unit
   import cpu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          TIMEOUT  = 16
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_start,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] k,
   input  logic [63:0] pc_in,
   input  logic [3:0]  alu_flags,
   input  logic        flags_we,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic [63:0] pc,
   output logic [3:0]  status,
   output logic        fetch_err
);

   // The wait counter only has to reach TIMEOUT-1.
   localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

   fetch_state_e  state_q;
   logic [63:0]   pc_q;
   logic [63:0]   pc_d;
   logic [31:0]   ir_q;
   logic [3:0]    status_q;
   logic [CW-1:0] cnt_q;
   logic          fetch_err_q;

   pc_next u_pc_next (
      .pc_i      (pc_q),
      .pc_sel_i  (pc_sel_e'(pc_sel)),
      .k_i       (k),
      .pc_in_i   (pc_in),
      .next_pc_o (pc_d)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         status_q    <= '0;
         cnt_q       <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         fetch_err_q <= 1'b0;
         // Status tracks the datapath regardless of fetch activity.
         if (flags_we)
            status_q <= alu_flags;
         case (state_q)
            ST_IDLE: begin
               pc_q <= pc_d;
               if (fetch_start) begin
                  state_q <= ST_FETCH;
                  cnt_q   <= '0;
               end
            end
            ST_FETCH: begin
               // PC is frozen so mem_addr stays stable for the whole read.
               // An ack on the last wait cycle still wins over the timeout.
               if (mem_ack) begin
                  ir_q    <= mem_rdata;
                  state_q <= ST_VALID;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  fetch_err_q <= 1'b1;
                  state_q     <= ST_IDLE;
                  cnt_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_VALID: begin
               // Same-cycle pc_sel and fetch_start: the read uses the new PC.
               pc_q <= pc_d;
               if (fetch_start) begin
                  state_q <= ST_FETCH;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign mem_req   = (state_q == ST_FETCH);
   assign ir_valid  = (state_q == ST_VALID);
   assign mem_addr  = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign status    = status_q;
   assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_status_unit.sv
// tb/tb_fetch_status_unit.sv - self-checking bench for fetch_status_unit

module tb_fetch_status_unit;

   localparam int TMO = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_start;
   logic [1:0]  pc_sel;
   logic [31:0] k;
   logic [63:0] pc_in;
   logic [3:0]  alu_flags;
   logic        flags_we;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] ir;
   logic        ir_valid;
   logic [63:0] pc;
   logic [3:0]  status;
   logic        fetch_err;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clock = ~clock;

   fetch_status_unit #(.RESET_PC(64'h0), .TIMEOUT(TMO)) dut (
      .clock       (clock),
      .reset       (reset),
      .fetch_start (fetch_start),
      .pc_sel      (pc_sel),
      .k           (k),
      .pc_in       (pc_in),
      .alu_flags   (alu_flags),
      .flags_we    (flags_we),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .pc          (pc),
      .status      (status),
      .fetch_err   (fetch_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: "busy" means a read is outstanding, "have_insn" means
   // the IR holds an unconsumed fresh instruction, waited counts unanswered cycles.
   logic [63:0] m_pc;
   logic [31:0] m_ir;
   logic [3:0]  m_status;
   bit          m_busy, m_have_insn, m_err;
   int          m_waited;

   always @(posedge clock) begin
      if (reset) begin
         m_pc = 64'h0; m_ir = 32'h0; m_status = 4'h0;
         m_busy = 0; m_have_insn = 0; m_err = 0; m_waited = 0;
      end else begin
         m_err = 0;
         if (flags_we) m_status = alu_flags;
         if (m_busy) begin
            if (mem_ack) begin
               m_ir = mem_rdata; m_busy = 0; m_have_insn = 1;
            end else begin
               m_waited = m_waited + 1;
               if (m_waited >= TMO) begin
                  m_err = 1; m_busy = 0;
               end
            end
         end else begin
            longint off;
            off = $signed(k);
            if (pc_sel == 2'd1) m_pc = m_pc + 64'd4;
            else if (pc_sel == 2'd2) m_pc = m_pc + 64'(off * 4);
            else if (pc_sel == 2'd3) m_pc = pc_in;
            if (fetch_start) begin
               m_busy = 1; m_have_insn = 0; m_waited = 0;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("cyc_mem_req",   64'(mem_req),   64'(m_busy));
         chk("cyc_mem_addr",  mem_addr,       m_pc);
         chk("cyc_pc",        pc,             m_pc);
         chk("cyc_ir",        64'(ir),        64'(m_ir));
         chk("cyc_ir_valid",  64'(ir_valid),  64'(m_have_insn));
         chk("cyc_status",    64'(status),    64'(m_status));
         chk("cyc_fetch_err", 64'(fetch_err), 64'(m_err));
      end
   end

   task automatic quiet();
      reset = 0; fetch_start = 0; pc_sel = 2'd0; k = '0; pc_in = '0;
      alu_flags = '0; flags_we = 0; mem_ack = 0; mem_rdata = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   initial begin
      quiet();
      reset = 1;
      tick();
      chk_en = 1;
      tick();
      reset = 0;
      tick();
      chk("rst_pc", pc, 64'h0);
      chk("rst_ir", 64'(ir), 64'h0);
      chk("rst_status", 64'(status), 64'h0);
      chk("rst_mem_req", 64'(mem_req), 64'h0);
      chk("rst_ir_valid", 64'(ir_valid), 64'h0);
      chk("rst_fetch_err", 64'(fetch_err), 64'h0);

      // Fetch answered on its third cycle
      fetch_start = 1;
      tick();
      fetch_start = 0;
      for (int i = 0; i < 3; i++) begin
         chk("f3_mem_req", 64'(mem_req), 64'h1);
         chk("f3_mem_addr", mem_addr, 64'h0);
         if (i == 2) begin mem_ack = 1; mem_rdata = 32'h8B020020; end
         tick();
      end
      mem_ack = 0;
      chk("f3_ir", 64'(ir), 64'h8B020020);
      chk("f3_ir_valid", 64'(ir_valid), 64'h1);
      chk("f3_mem_req_low", 64'(mem_req), 64'h0);

      // Branch backwards then step
      pc_sel = 2'd3; pc_in = 64'h100; tick();
      pc_sel = 2'd2; k = 32'hFFFFFFFE; tick();
      chk("br_pc", pc, 64'hF8);
      pc_sel = 2'd1; tick();
      chk("inc_pc", pc, 64'hFC);
      chk("br_ir_valid", 64'(ir_valid), 64'h1);

      // Wrap
      pc_sel = 2'd3; pc_in = 64'hFFFFFFFFFFFFFFFC; tick();
      pc_sel = 2'd1; tick();
      chk("wrap_pc", pc, 64'h0);
      pc_sel = 2'd0;

      // Timeout: 16 unanswered cycles
      fetch_start = 1; tick(); fetch_start = 0;
      for (int i = 1; i < TMO; i++) begin
         chk("tmo_no_err_early", 64'(fetch_err), 64'h0);
         tick();
      end
      chk("tmo_req_last", 64'(mem_req), 64'h1);
      tick();
      chk("tmo_err", 64'(fetch_err), 64'h1);
      chk("tmo_idle_req", 64'(mem_req), 64'h0);
      chk("tmo_ir_kept", 64'(ir), 64'h8B020020);
      tick();
      chk("tmo_err_once", 64'(fetch_err), 64'h0);

      // Ack on the 16th cycle wins
      fetch_start = 1; tick(); fetch_start = 0;
      for (int i = 1; i < TMO; i++) tick();
      mem_ack = 1; mem_rdata = 32'h12345678; tick(); mem_ack = 0;
      chk("ack16_err", 64'(fetch_err), 64'h0);
      chk("ack16_ir", 64'(ir), 64'h12345678);
      chk("ack16_valid", 64'(ir_valid), 64'h1);

      // pc_sel ignored and flags written during FETCH
      fetch_start = 1; tick(); fetch_start = 0;
      pc_sel = 2'd3; pc_in = 64'h4000; flags_we = 1; alu_flags = 4'b0110; tick();
      flags_we = 0;
      chk("fl_status", 64'(status), 64'h6);
      chk("fl_pc_frozen", pc, 64'h0);
      tick();
      chk("fl_addr_frozen", mem_addr, 64'h0);
      mem_ack = 1; mem_rdata = 32'hA5A5A5A5; tick(); mem_ack = 0;
      chk("fl_pc_after_ack", pc, 64'h0);
      tick();
      chk("fl_pc_loaded", pc, 64'h4000);
      pc_sel = 2'd0;

      // Reset in FETCH cycle 2 with an ack present
      fetch_start = 1; tick(); fetch_start = 0;
      tick();
      reset = 1; mem_ack = 1; mem_rdata = 32'hDEADBEEF; tick();
      quiet();
      chk("rst_mid_ir", 64'(ir), 64'h0);
      chk("rst_mid_req", 64'(mem_req), 64'h0);
      chk("rst_mid_pc", pc, 64'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         reset       = ($urandom_range(0, 199) == 0);
         fetch_start = ($urandom_range(0, 2) == 0);
         pc_sel      = 2'($urandom_range(0, 3));
         k           = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
         pc_in       = {$urandom, $urandom};
         flags_we    = ($urandom_range(0, 3) == 0);
         alu_flags   = 4'($urandom);
         mem_ack     = ((i / 200) % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 40) == 0);
         mem_rdata   = $urandom;
         tick();
      end
      quiet();
      tick();
      chk_en = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_status_unit.md
FETCH_STATUS_UNIT -- requirements
Module: fetch_status_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 64'h0, meaning PC value loaded on reset.
REQ-002 SHALL provide parameter TIMEOUT, default 16, meaning max cycles to wait for mem_ack before fault.
REQ-003 SHALL have port: clock  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: fetch_start  input  1  control side requests next instruction.
REQ-006 SHALL have port: pc_sel  input  2  PC update: 00 hold, 01 +4, 10 PC-relative branch, 11 load pc_in.
REQ-007 SHALL have port: k  input  32  sign-extended word offset for pc_sel=10.
REQ-008 SHALL have port: pc_in  input  64  absolute target for pc_sel=11.
REQ-009 SHALL have port: alu_flags  input  4  NZCV from datapath.
REQ-010 SHALL have port: flags_we  input  1  status register write enable.
REQ-011 SHALL have port: mem_req  output  1  instruction memory read request.
REQ-012 SHALL have port: mem_addr  output  64  read address (equals pc).
REQ-013 SHALL have port: mem_rdata  input  32  instruction word, valid with mem_ack.
REQ-014 SHALL have port: mem_ack  input  1  memory completes read this cycle.
REQ-015 SHALL have port: ir  output  32  latched instruction register.
REQ-016 SHALL have port: ir_valid  output  1  ir holds a freshly fetched instruction.
REQ-017 SHALL have port: pc  output  64  current program counter.
REQ-018 SHALL have port: status  output  4  registered NZCV flags.
REQ-019 SHALL have port: fetch_err  output  1  one-cycle pulse on fetch timeout.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, VALID.
REQ-021 IDLE: mem_req=0, ir_valid=0; fetch_start=1 -> FETCH next cycle.
REQ-022 FETCH: mem_req=1, mem_addr=pc, held until mem_ack or timeout; fetch_start ignored.
REQ-023 FETCH with mem_ack=1: ir<=mem_rdata at that edge, next state VALID, mem_req low next cycle.
REQ-024 FETCH: wait counter increments each cycle without ack; when counter reaches TIMEOUT-1 without ack -> fetch_err=1 for one cycle, ir unchanged, next state IDLE, counter cleared.
REQ-025 mem_ack on the timeout cycle SHALL take priority: instruction latched, no fetch_err.
REQ-026 VALID: ir_valid=1, ir stable; fetch_start=1 -> FETCH, ir_valid=0 from next cycle.
REQ-027 mem_ack outside FETCH SHALL be ignored.
REQ-028 pc_sel applied at edge in IDLE and VALID only; ignored in FETCH so mem_addr stays stable.
REQ-029 pc_sel=01: pc<=pc+4; 10: pc<=pc+({{32{k[31]}},k}<<2); 11: pc<=pc_in; all modulo 2^64, wrap silently.
REQ-030 pc_sel and fetch_start in same VALID cycle: PC updates and FETCH starts; first mem_addr is the updated pc.
REQ-031 flags_we=1: status<=alu_flags at edge, in any state, independent of fetch activity.
REQ-032 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-033 reset=1 SHALL set pc=RESET_PC, ir=0, status=0, state=IDLE, counter=0, mem_req=0, ir_valid=0, fetch_err=0, taking priority over every other input.
REQ-034 Reset mid-FETCH SHALL drop mem_req the following cycle; mem_ack during reset discarded.

Structure
REQ-035 pc_sel encodings, FSM state encodings and NZCV bit positions (N=3,Z=2,C=1,V=0) SHALL reside in shared package cpu_pkg.
REQ-036 PC next-value logic SHALL be one sub-module pc_next (pc, pc_sel, k, pc_in -> next pc); FSM, counter and registers stay in top.

Verification
REQ-037 Reset, fetch_start, mem_ack after 3 cycles with rdata=32'h8B020020 -> mem_addr=0 for 3 cycles, ir=32'h8B020020, ir_valid=1.
REQ-038 In VALID, pc=0x100, pc_sel=10, k=32'hFFFFFFFE -> pc=0xF8; then pc_sel=01 -> 0xFC.
REQ-039 pc=64'hFFFFFFFFFFFFFFFC, pc_sel=01 -> pc=0 (wrap).
REQ-040 fetch_start, no mem_ack for TIMEOUT=16 cycles -> fetch_err pulse exactly once, state IDLE, ir unchanged; mem_ack on 16th cycle -> latch, no error.
REQ-041 pc_sel=11, pc_in=0x4000 during FETCH -> pc unchanged until FETCH exits; flags_we=1 alu_flags=4'b0110 mid-FETCH -> status=4'b0110 next cycle.
REQ-042 reset asserted in FETCH cycle 2 with mem_ack=1 -> ir=0, mem_req=0, pc=RESET_PC next cycle.
